// File: rtl/ss_updown_counter.sv
// Purpose: debounced up/down/clear push-button counter (hex or BCD) with a multiplexed 7-segment display driver.
// Latency: 2 sync flops + DEBOUNCE_TICKS scan ticks to a press pulse; count_o updates 1 clock after a pulse or load.
// Backpressure: none; buttons are level-sampled and load_i is accepted (or rejected as invalid BCD) on the cycle it is high.
module ss_updown_counter #(
  parameter int DIGITS         = 4,
  parameter int SCAN_DIV_BITS  = 17,
  parameter int DEBOUNCE_TICKS = 4,
  parameter int DECIMAL        = 0,
  parameter int SATURATE       = 0
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                btn_up_i,
  input  logic                btn_down_i,
  input  logic                btn_clr_i,
  input  logic                load_i,
  input  logic [4*DIGITS-1:0] load_value_i,
  output logic [4*DIGITS-1:0] count_o,
  output logic                wrap_o,
  output logic [DIGITS-1:0]   anode_bits_o,
  output logic [6:0]          cathode_bits_o
);

  localparam int         W         = 4 * DIGITS;
  localparam int         IDX_W     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int         DB_W      = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [3:0] DIGIT_MAX = (DECIMAL != 0) ? 4'd9 : 4'd15;
  localparam bit         SAT       = (SATURATE != 0);

  // Button vectors are ordered {clr, down, up}.
  logic [2:0]            sync1, sync2;
  logic [2:0]            db_lvl, press;
  logic [2:0][DB_W-1:0]  db_cnt;
  logic [SCAN_DIV_BITS-1:0] scan_cnt;
  logic                  scan_tick;
  logic [W-1:0]          count_q, count_nxt;
  logic                  wrap_q, wrap_nxt;
  logic [W:0]            inc_res, dec_res;
  logic                  load_ok;
  logic [IDX_W-1:0]      idx_q;
  logic [DIGITS-1:0]     anode_q;
  logic [6:0]            cathode_q;
  logic [3:0]            cur_nib;

  // Ripple one step through the nibbles; the MSB of the result is the carry/borrow out,
  // which is set only when every nibble rolled over (i.e. the count was at its limit).
  function automatic logic [W:0] nib_step(input logic [W-1:0] v, input logic up);
    logic [W-1:0] r;
    logic         c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (c) begin
        if (up) begin
          if (v[4*i +: 4] == DIGIT_MAX) r[4*i +: 4] = 4'd0;
          else begin
            r[4*i +: 4] = v[4*i +: 4] + 4'd1;
            c = 1'b0;
          end
        end else begin
          if (v[4*i +: 4] == 4'd0) r[4*i +: 4] = DIGIT_MAX;
          else begin
            r[4*i +: 4] = v[4*i +: 4] - 4'd1;
            c = 1'b0;
          end
        end
      end
    end
    return {c, r};
  endfunction

  // Active-low {g,f,e,d,c,b,a} hex glyphs.
  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'b1000000;  4'h1: glyph = 7'b1111001;
      4'h2: glyph = 7'b0100100;  4'h3: glyph = 7'b0110000;
      4'h4: glyph = 7'b0011001;  4'h5: glyph = 7'b0010010;
      4'h6: glyph = 7'b0000010;  4'h7: glyph = 7'b1111000;
      4'h8: glyph = 7'b0000000;  4'h9: glyph = 7'b0010000;
      4'hA: glyph = 7'b0001000;  4'hB: glyph = 7'b0000011;
      4'hC: glyph = 7'b1000110;  4'hD: glyph = 7'b0100001;
      4'hE: glyph = 7'b0000110;  default: glyph = 7'b0001110;
    endcase
  endfunction

  assign scan_tick = &scan_cnt;
  assign inc_res   = nib_step(count_q, 1'b1);
  assign dec_res   = nib_step(count_q, 1'b0);
  assign cur_nib   = count_q[{idx_q, 2'b00} +: 4];

  // Two-flop synchronizers for the raw buttons.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {btn_clr_i, btn_down_i, btn_up_i};
      sync2 <= sync1;
    end
  end

  // Free-running scan divider; the tick is the all-ones cycle.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) scan_cnt <= '0;
    else         scan_cnt <= scan_cnt + 1'b1;
  end

  // Debounce on scan ticks and emit a one-cycle pulse on each accepted rising level.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      db_lvl <= '0;
      db_cnt <= '0;
      press  <= '0;
    end else begin
      press <= '0;
      if (scan_tick) begin
        for (int b = 0; b < 3; b++) begin
          if (sync2[b] == db_lvl[b]) begin
            db_cnt[b] <= '0;
          end else if (db_cnt[b] == DB_W'(DEBOUNCE_TICKS - 1)) begin
            db_lvl[b] <= sync2[b];
            db_cnt[b] <= '0;
            press[b]  <= sync2[b];
          end else begin
            db_cnt[b] <= db_cnt[b] + 1'b1;
          end
        end
      end
    end
  end

  // In BCD mode a load with any nibble above 9 is rejected outright.
  always_comb begin
    load_ok = 1'b1;
    if (DECIMAL != 0) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (load_value_i[4*i +: 4] > 4'd9) load_ok = 1'b0;
      end
    end
  end

  // Next count by priority: clear, load, up+down cancel, up, down.
  always_comb begin
    count_nxt = count_q;
    wrap_nxt  = 1'b0;
    if (press[2]) begin
      count_nxt = '0;
    end else if (load_i) begin
      if (load_ok) count_nxt = load_value_i;
    end else if (press[0] && press[1]) begin
      count_nxt = count_q;
    end else if (press[0]) begin
      if (!(SAT && inc_res[W])) begin
        count_nxt = inc_res[W-1:0];
        wrap_nxt  = inc_res[W];
      end
    end else if (press[1]) begin
      if (!(SAT && dec_res[W])) begin
        count_nxt = dec_res[W-1:0];
        wrap_nxt  = dec_res[W];
      end
    end
  end

  // Registered count and wrap pulse.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_nxt;
      wrap_q  <= wrap_nxt;
    end
  end

  // Display scan: on each tick drive the current digit, then advance the index.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      idx_q     <= '0;
      anode_q   <= '1;
      cathode_q <= 7'b1111111;
    end else if (scan_tick) begin
      anode_q   <= ~(DIGITS'(1) << idx_q);
      cathode_q <= glyph(cur_nib);
      idx_q     <= (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
  end

  assign count_o        = count_q;
  assign wrap_o         = wrap_q;
  assign anode_bits_o   = anode_q;
  assign cathode_bits_o = cathode_q;

endmodule

// File: tb/tb_ss_updown_counter.sv
// Bench for ss_updown_counter: hex-wrap, BCD-wrap, hex-saturate and 1-digit instances share one stimulus.
// Expected counts and wrap totals come from a bench-side model pushed to a scoreboard queue.
module tb_ss_updown_counter;

  localparam int OP_UP = 0, OP_DN = 1, OP_CLR = 2, OP_UD = 3, OP_LOAD = 4;

  typedef struct {
    logic [15:0] h, d, s;
    int          wh, wd, ws;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        btn_up = 1'b0, btn_down = 1'b0, btn_clr = 1'b0, load = 1'b0;
  logic [15:0] load_value = 16'h0;

  logic [15:0] cnt_h, cnt_d, cnt_s;
  logic        wrap_h, wrap_d, wrap_s, wrap_1;
  logic [3:0]  an_h, an_d, an_s, cnt_1;
  logic [0:0]  an_1;
  logic [6:0]  ca_h, ca_d, ca_s, ca_1;

  int n_tests = 0, n_fail = 0;
  int wt_h = 0, wt_d = 0, wt_s = 0;

  logic [15:0] mh = 16'h0, md = 16'h0, ms = 16'h0;
  int          eh = 0, ed = 0, es = 0;
  exp_t        exp_q[$];

  always #5 clk = ~clk;

  ss_updown_counter #(.DIGITS(4), .SCAN_DIV_BITS(2), .DEBOUNCE_TICKS(2), .DECIMAL(0), .SATURATE(0)) u_hex (
    .clk_i(clk), .reset_i(rst), .btn_up_i(btn_up), .btn_down_i(btn_down), .btn_clr_i(btn_clr),
    .load_i(load), .load_value_i(load_value), .count_o(cnt_h), .wrap_o(wrap_h),
    .anode_bits_o(an_h), .cathode_bits_o(ca_h));

  ss_updown_counter #(.DIGITS(4), .SCAN_DIV_BITS(2), .DEBOUNCE_TICKS(2), .DECIMAL(1), .SATURATE(0)) u_dec (
    .clk_i(clk), .reset_i(rst), .btn_up_i(btn_up), .btn_down_i(btn_down), .btn_clr_i(btn_clr),
    .load_i(load), .load_value_i(load_value), .count_o(cnt_d), .wrap_o(wrap_d),
    .anode_bits_o(an_d), .cathode_bits_o(ca_d));

  ss_updown_counter #(.DIGITS(4), .SCAN_DIV_BITS(2), .DEBOUNCE_TICKS(2), .DECIMAL(0), .SATURATE(1)) u_sat (
    .clk_i(clk), .reset_i(rst), .btn_up_i(btn_up), .btn_down_i(btn_down), .btn_clr_i(btn_clr),
    .load_i(load), .load_value_i(load_value), .count_o(cnt_s), .wrap_o(wrap_s),
    .anode_bits_o(an_s), .cathode_bits_o(ca_s));

  ss_updown_counter #(.DIGITS(1), .SCAN_DIV_BITS(2), .DEBOUNCE_TICKS(2), .DECIMAL(0), .SATURATE(0)) u_one (
    .clk_i(clk), .reset_i(rst), .btn_up_i(btn_up), .btn_down_i(btn_down), .btn_clr_i(btn_clr),
    .load_i(load), .load_value_i(load_value[3:0]), .count_o(cnt_1), .wrap_o(wrap_1),
    .anode_bits_o(an_1), .cathode_bits_o(ca_1));

  // Running totals of wrap_o high cycles; a single pulse adds exactly one.
  always @(posedge clk) begin
    if (wrap_h === 1'b1) wt_h <= wt_h + 1;
    if (wrap_d === 1'b1) wt_d <= wt_d + 1;
    if (wrap_s === 1'b1) wt_s <= wt_s + 1;
  end

  function automatic int bcd2int(input logic [15:0] v);
    return int'(v[15:12]) * 1000 + int'(v[11:8]) * 100 + int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic logic [15:0] int2bcd(input int n);
    return {4'(n / 1000), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  function automatic bit bcd_ok(input logic [15:0] v);
    return (v[15:12] <= 4'd9) && (v[11:8] <= 4'd9) && (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  task automatic clk_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_step(input int dir);
    int v;
    if (dir > 0) begin
      if (mh == 16'hFFFF) eh++;
      mh = mh + 16'd1;
      if (ms != 16'hFFFF) ms = ms + 16'd1;
    end else begin
      if (mh == 16'h0000) eh++;
      mh = mh - 16'd1;
      if (ms != 16'h0000) ms = ms - 16'd1;
    end
    v = bcd2int(md);
    if (dir > 0) begin
      if (v == 9999) begin ed++; v = 0; end else v++;
    end else begin
      if (v == 0) begin ed++; v = 9999; end else v--;
    end
    md = int2bcd(v);
  endtask

  task automatic push_exp();
    exp_q.push_back('{mh, md, ms, eh, ed, es});
  endtask

  // Drive one operation (button press/release or one-cycle load) and push the model's result.
  task automatic do_op(input int kind, input logic [15:0] v);
    if (kind == OP_LOAD) begin
      load_value = v;
      load = 1'b1;
      clk_n(1);
      load = 1'b0;
      mh = v;
      ms = v;
      if (bcd_ok(v)) md = v;
    end else begin
      btn_up   = (kind == OP_UP)  || (kind == OP_UD);
      btn_down = (kind == OP_DN)  || (kind == OP_UD);
      btn_clr  = (kind == OP_CLR);
      clk_n(24);
      btn_up = 1'b0; btn_down = 1'b0; btn_clr = 1'b0;
      clk_n(24);
      if (kind == OP_CLR) begin mh = 16'h0; md = 16'h0; ms = 16'h0; end
      else if (kind == OP_UP) model_step(1);
      else if (kind == OP_DN) model_step(-1);
    end
    push_exp();
  endtask

  // Return just after the next display update edge of the hex instance.
  task automatic wait_tick();
    logic [3:0] p;
    bit ok;
    p = an_h;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      clk_n(1);
      if (an_h !== p) ok = 1'b1;
    end
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL scan_tick: anode stuck at %b, required a change within 20 clocks", an_h);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    clk_n(3);
    rst = 1'b0;
    mh = 16'h0; md = 16'h0; ms = 16'h0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clk_n(3);
    n_tests++;
    if ({cnt_h, cnt_d, cnt_s} !== 48'h0) begin
      n_fail++; $display("FAIL reset_count: got %h %h %h, required 0", cnt_h, cnt_d, cnt_s);
    end
    n_tests++;
    if ({wrap_h, wrap_d, wrap_s} !== 3'b000) begin
      n_fail++; $display("FAIL reset_wrap: got %b, required 000", {wrap_h, wrap_d, wrap_s});
    end
    n_tests++;
    if (an_h !== 4'b1111 || an_1 !== 1'b1) begin
      n_fail++; $display("FAIL reset_anode: got %b/%b, required 1111/1", an_h, an_1);
    end
    n_tests++;
    if (ca_h !== 7'b1111111) begin
      n_fail++; $display("FAIL reset_cathode: got %b, required 1111111", ca_h);
    end
    rst = 1'b0;
    wait_tick();
    n_tests++;
    if (an_h !== 4'b1110 || ca_h !== 7'b1000000) begin
      n_fail++; $display("FAIL first_tick: got anode %b cathode %b, required 1110 1000000", an_h, ca_h);
    end
    n_tests++;
    if (an_1 !== 1'b0) begin
      n_fail++; $display("FAIL one_digit_anode: got %b, required 0", an_1);
    end
  endtask

  task automatic test_hold40();
    exp_t e;
    apply_reset();
    btn_up = 1'b1;
    clk_n(40);
    btn_up = 1'b0;
    clk_n(24);
    model_step(1);
    push_exp();
    e = exp_q.pop_front();
    n_tests++;
    if ({cnt_h, cnt_d, cnt_s, wt_h, wt_d, wt_s} !== {e.h, e.d, e.s, e.wh, e.wd, e.ws}) begin
      n_fail++;
      $display("FAIL hold40: got %h %h %h wraps %0d %0d %0d, required %h %h %h wraps %0d %0d %0d",
               cnt_h, cnt_d, cnt_s, wt_h, wt_d, wt_s, e.h, e.d, e.s, e.wh, e.wd, e.ws);
    end
  endtask

  task automatic test_glitch();
    exp_t e;
    do_op(OP_CLR, 16'h0);
    void'(exp_q.pop_front());
    for (int g = 0; g < 3; g++) begin
      wait_tick();
      btn_up = 1'b1;
      clk_n(4);
      btn_up = 1'b0;
      clk_n(12);
    end
    push_exp();
    e = exp_q.pop_front();
    n_tests++;
    if ({cnt_h, cnt_d, cnt_s} !== {e.h, e.d, e.s}) begin
      n_fail++; $display("FAIL glitch: got %h %h %h, required %h %h %h", cnt_h, cnt_d, cnt_s, e.h, e.d, e.s);
    end
  endtask

  task automatic test_decimal();
    int          kinds[3];
    logic [15:0] vals[3];
    exp_t        e;
    kinds = '{OP_LOAD, OP_UP, OP_LOAD};
    vals  = '{16'h9999, 16'h0, 16'h12A4};
    for (int i = 0; i < 3; i++) begin
      do_op(kinds[i], vals[i]);
      e = exp_q.pop_front();
      n_tests++;
      if ({cnt_h, cnt_d, cnt_s, wt_h, wt_d, wt_s} !== {e.h, e.d, e.s, e.wh, e.wd, e.ws}) begin
        n_fail++;
        $display("FAIL decimal[%0d]: got %h %h %h wraps %0d %0d %0d, required %h %h %h wraps %0d %0d %0d",
                 i, cnt_h, cnt_d, cnt_s, wt_h, wt_d, wt_s, e.h, e.d, e.s, e.wh, e.wd, e.ws);
      end
    end
  endtask

  task automatic test_saturate();
    int          kinds[4];
    logic [15:0] vals[4];
    exp_t        e;
    kinds = '{OP_LOAD, OP_DN, OP_LOAD, OP_UP};
    vals  = '{16'h0000, 16'h0, 16'hFFFF, 16'h0};
    for (int i = 0; i < 4; i++) begin
      do_op(kinds[i], vals[i]);
      e = exp_q.pop_front();
      n_tests++;
      if ({cnt_h, cnt_d, cnt_s, wt_h, wt_d, wt_s} !== {e.h, e.d, e.s, e.wh, e.wd, e.ws}) begin
        n_fail++;
        $display("FAIL saturate[%0d]: got %h %h %h wraps %0d %0d %0d, required %h %h %h wraps %0d %0d %0d",
                 i, cnt_h, cnt_d, cnt_s, wt_h, wt_d, wt_s, e.h, e.d, e.s, e.wh, e.wd, e.ws);
      end
    end
  endtask

  task automatic test_display();
    logic [3:0] ean[4];
    logic [6:0] eca[4];
    int         guard;
    exp_t       e;
    ean = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    eca = '{7'b1000000, 7'b0000000, 7'b0001000, 7'b1111001};
    do_op(OP_LOAD, 16'h1A80);
    e = exp_q.pop_front();
    n_tests++;
    if (cnt_h !== e.h) begin
      n_fail++; $display("FAIL display_load: got %h, required %h", cnt_h, e.h);
    end
    clk_n(16);
    guard = 0;
    while (an_h !== 4'b1110 && guard < 8) begin
      wait_tick();
      guard++;
    end
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (an_h !== ean[k] || ca_h !== eca[k]) begin
        n_fail++;
        $display("FAIL display[%0d]: got anode %b cathode %b, required %b %b", k, an_h, ca_h, ean[k], eca[k]);
      end
      clk_n(4);
    end
  endtask

  task automatic test_updown_clr();
    exp_t e;
    do_op(OP_LOAD, 16'h0005);
    void'(exp_q.pop_front());
    do_op(OP_UD, 16'h0);
    e = exp_q.pop_front();
    n_tests++;
    if ({cnt_h, cnt_d, cnt_s} !== {e.h, e.d, e.s}) begin
      n_fail++; $display("FAIL up_down: got %h %h %h, required %h %h %h", cnt_h, cnt_d, cnt_s, e.h, e.d, e.s);
    end
    // Line the load strobe up with the clear pulse: pulse is high in the cycle after the second tick.
    wait_tick();
    btn_clr = 1'b1;
    clk_n(8);
    load_value = 16'h1234;
    load = 1'b1;
    clk_n(1);
    load = 1'b0;
    mh = 16'h0; md = 16'h0; ms = 16'h0;
    push_exp();
    e = exp_q.pop_front();
    n_tests++;
    if ({cnt_h, cnt_d, cnt_s} !== {e.h, e.d, e.s}) begin
      n_fail++; $display("FAIL clr_vs_load: got %h %h %h, required %h %h %h", cnt_h, cnt_d, cnt_s, e.h, e.d, e.s);
    end
    btn_clr = 1'b0;
    clk_n(24);
  endtask

  task automatic test_reset_debounce();
    exp_t e;
    do_op(OP_LOAD, 16'h0003);
    void'(exp_q.pop_front());
    // Press interrupted by reset and released before reset ends: no press may survive.
    wait_tick();
    btn_up = 1'b1;
    clk_n(5);
    rst = 1'b1;
    clk_n(2);
    btn_up = 1'b0;
    clk_n(2);
    rst = 1'b0;
    mh = 16'h0; md = 16'h0; ms = 16'h0;
    clk_n(30);
    push_exp();
    e = exp_q.pop_front();
    n_tests++;
    if ({cnt_h, cnt_d, cnt_s} !== {e.h, e.d, e.s}) begin
      n_fail++; $display("FAIL reset_mid_press: got %h %h %h, required %h %h %h", cnt_h, cnt_d, cnt_s, e.h, e.d, e.s);
    end
    // Button held through reset release: one press, but only after a full debounce.
    btn_up = 1'b1;
    clk_n(5);
    rst = 1'b1;
    clk_n(3);
    rst = 1'b0;
    clk_n(3);
    push_exp();
    e = exp_q.pop_front();
    n_tests++;
    if (cnt_h !== e.h) begin
      n_fail++; $display("FAIL held_early: got %h, required %h", cnt_h, e.h);
    end
    clk_n(30);
    btn_up = 1'b0;
    clk_n(24);
    model_step(1);
    push_exp();
    e = exp_q.pop_front();
    n_tests++;
    if ({cnt_h, cnt_d, cnt_s} !== {e.h, e.d, e.s}) begin
      n_fail++; $display("FAIL held_through_reset: got %h %h %h, required %h %h %h", cnt_h, cnt_d, cnt_s, e.h, e.d, e.s);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_hold40();
    test_glitch();
    test_decimal();
    test_saturate();
    test_display();
    test_updown_clr();
    test_reset_debounce();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ss_updown_counter.md
SS_UPDOWN_COUNTER -- requirements
Module: ss_updown_counter

Interface
REQ-001 Parameter DIGITS, default 4: number of display digits and counter nibbles; legal range 1..8.
REQ-002 Parameter SCAN_DIV_BITS, default 17: a scan tick occurs every 2^SCAN_DIV_BITS clocks.
REQ-003 Parameter DEBOUNCE_TICKS, default 4: number of consecutive equal scan-tick samples needed to accept a button level change.
REQ-004 Parameter DECIMAL, default 0: 0 selects a hex counter; 1 selects a per-digit BCD counter.
REQ-005 Parameter SATURATE, default 0: 0 makes the counter wrap at its limits; 1 makes it hold at its limits.
REQ-006 The block SHALL have one clock, clk_i; reset is reset_i, asynchronous and active-high.
REQ-007 Ports SHALL be, in order (name, direction, width, meaning):
- clk_i, in, 1: system clock.
- reset_i, in, 1: async active-high reset.
- btn_up_i, in, 1: raw asynchronous increment button.
- btn_down_i, in, 1: raw asynchronous decrement button.
- btn_clr_i, in, 1: raw asynchronous clear button.
- load_i, in, 1: synchronous one-cycle load strobe.
- load_value_i, in, 4*DIGITS: value to load.
- count_o, out, 4*DIGITS: current count.
- wrap_o, out, 1: one-cycle pulse when the count wraps.
- anode_bits_o, out, DIGITS: active-low digit enables.
- cathode_bits_o, out, 7: active-low segments {g,f,e,d,c,b,a}.

Function
REQ-008 Each raw button SHALL pass through a 2-flop synchronizer clocked every clk_i cycle.
REQ-009 The scan tick SHALL be a free-running counter of SCAN_DIV_BITS bits, asserting a one-cycle tick when the counter equals all-ones.
REQ-010 Debounce: each synchronized button SHALL be sampled only on a scan tick; the debounced level changes after DEBOUNCE_TICKS consecutive samples differ from the current debounced level.
REQ-011 A sample equal to the current debounced level SHALL clear that button's debounce count.
REQ-012 Each debounced rising edge SHALL produce exactly one single-cycle press pulse; releases SHALL produce nothing; holding a button SHALL NOT auto-repeat.
REQ-013 Counter update priority per cycle, highest first:
- clr pulse sets the count to 0;
- load_i loads load_value_i;
- up and down pulses in the same cycle leave the count unchanged;
- an up pulse alone increments;
- a down pulse alone decrements.
REQ-014 Hex mode: the count SHALL be modulo 2^(4*DIGITS); the maximum is all F nibbles.
REQ-015 Decimal mode: each nibble SHALL stay in 0..9 with BCD carry and borrow; the maximum is 10^DIGITS-1 (all 9 nibbles).
REQ-016 Decimal mode: a load_i whose load_value_i has any nibble greater than 9 SHALL be ignored and the count SHALL be unchanged.
REQ-017 Wrap mode: increment at maximum gives 0; decrement at 0 gives maximum; wrap_o SHALL pulse high for the cycle after the update.
REQ-018 Saturate mode: increment at maximum and decrement at 0 SHALL leave the count unchanged; wrap_o SHALL stay 0.
REQ-019 count_o SHALL be registered and SHALL update the cycle after the pulse or load; press-to-count latency from a debounced edge is 1 clock.
REQ-020 The display digit index SHALL advance on each scan tick, cycling 0,1,..,DIGITS-1,0.
REQ-021 anode_bits_o SHALL drive low only the bit of the current digit index.
REQ-022 cathode_bits_o SHALL show the hex glyph of count_o nibble [index]: 0=1000000, 1=1111001, 8=0000000, A=0001000, F=0001110.
REQ-023 anode_bits_o and cathode_bits_o SHALL be registered and SHALL update only on a scan tick, so each digit is stable for one full scan period.
REQ-024 With DIGITS=1, the index SHALL stay 0 and anode_bits_o SHALL be 0 after the first scan tick.

Reset
REQ-025 While reset_i is high, the block SHALL hold:
- count_o=0, wrap_o=0;
- anode_bits_o all ones, cathode_bits_o=1111111;
- digit index 0, scan counter 0;
- synchronizers, debounced levels and debounce counts 0.
REQ-026 Reset asserted mid-press or mid-debounce SHALL discard the pending press; a button held through reset release SHALL produce one press only after a full debounce from level 0.
REQ-027 The first scan tick after reset SHALL enable digit 0 with the glyph of nibble 0.

Verification (SCAN_DIV_BITS=2, DEBOUNCE_TICKS=2, DIGITS=4 unless stated)
REQ-028 Hold btn_up_i high for 40 clocks from reset -> count_o=0x0001, a single increment.
REQ-029 btn_up_i glitch high for 1 scan tick, 3 times -> count_o stays 0x0000.
REQ-030 DECIMAL=1: load 0x9999 then one up press -> count_o=0x0000 and wrap_o high for exactly 1 cycle. Load 0x12A4 -> ignored.
REQ-031 SATURATE=1, hex: load 0x0000 then a down press -> count_o=0x0000 and wrap_o=0. Load 0xFFFF then an up press -> 0xFFFF.
REQ-032 Count 0x1A80 -> over 4 consecutive scan ticks:
- anode_bits_o = 1110, 1101, 1011, 0111;
- cathode_bits_o = 1000000, 0000000, 0001000, 1111001.
REQ-033 Up and down press pulses in the same cycle with count 0x0005 -> stays 0x0005. Clear with simultaneous load_i -> 0x0000. Reset mid-debounce -> count 0 and no later pulse.
